// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_EXC  = 0;
  localparam int unsigned FLAG_W    = 3;

  function automatic logic [FLAG_W-1:0] mk_flags(input logic zero, input logic neg,
                                                 input logic exc);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = zero;
    f[FLAG_NEG]  = neg;
    f[FLAG_EXC]  = exc;
    return f;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or restoring divide (mode=1).
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Multiply: {hi,lo} is the product, lo holds remaining multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (!mode) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_n = diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_n = shifted[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [2:0]        ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state, state_n;
  op_e             op_in, op_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, spec_q;
  logic            accept, last;
  logic            a_sgn, b_sgn, neg_a, neg_b, div0, ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_res, hi_n, lo_n, fin_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode (state == DIV),
    .hi   (hi_q),
    .lo   (lo_q),
    .opnd (opnd_q),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  // Operand decode: magnitudes, signs and the two special division cases.
  always_comb begin
    op_in    = op_e'(ctrl);
    a_sgn    = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op_in inside {OP_MULH, OP_DIV, OP_REM};
    neg_a    = a_sgn & src_a[XLEN-1];
    neg_b    = b_sgn & src_b[XLEN-1];
    mag_a    = neg_a ? -src_a : src_a;
    mag_b    = neg_b ? -src_b : src_b;
    div0     = ctrl[2] && (src_b == '0);
    ovf      = (op_in inside {OP_DIV, OP_REM}) && (src_a == MIN_INT) && (src_b == '1);
    special  = div0 | ovf;
    if (div0) spec_res = ctrl[1] ? src_a : '1;
    else      spec_res = ctrl[1] ? '0 : MIN_INT;
  end

  // Next-state logic; flush overrides both accept and result handshake.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = (cnt_q == CW'(1));
    case (state)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_n = (ctrl[2] || special) ? DIV : MUL;
      end
      MUL, DIV: if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      accept  = 1'b0;
    end
  end

  // Sign-corrected final value from the last iteration (or the latched special result).
  always_comb begin
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    if (spec_q) fin_res = lo_q;
    else begin
      case (op_q)
        OP_MUL:                        fin_res = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:               fin_res = neg_q ? -lo_n : lo_n;
        default:                       fin_res = neg_q ? -hi_n : hi_n;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == DONE);
      in_ready  <= (state_n == IDLE);
      busy      <= (state_n == MUL) || (state_n == DIV);
    end
  end

  // Special cases ride one DIV cycle with the answer parked in lo_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_q   <= op_in;
        hi_q   <= '0;
        lo_q   <= special ? spec_res : (ctrl[2] ? mag_a : mag_b);
        opnd_q <= ctrl[2] ? mag_b : mag_a;
        cnt_q  <= special ? CW'(1) : CW'(XLEN);
        neg_q  <= (ctrl[2] && ctrl[1]) ? neg_a : (neg_a ^ neg_b);
        spec_q <= special;
      end else if (state == MUL || state == DIV) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - CW'(1);
        if (last) begin
          result <= fin_res;
          flags  <= mk_flags(fin_res == '0, fin_res[XLEN-1], spec_q);
        end
      end
    end
  end

endmodule
